// File: rtl/bsg_manycore_dpi_req_buffer.sv
// -----------------------------------------------------------------------------
// bsg_manycore_dpi_req_buffer
//
// Request staging buffer between the DPI host tile model and the endpoint
// FIFO adapter request port. The host side pushes request words without
// regard to backpressure. This block queues them in a small circular buffer
// and releases them toward the endpoint only while remote credits are
// available. Fence and flush controls let the host wait until every
// outstanding request has completed, or discard queued work.
//
// Ports:
//   clk_i                - clock
//   reset_i              - synchronous active-high reset
//   host_req_v_i         - host request valid
//   host_req_data_i      - host request word
//   host_req_ready_o     - buffer accepts a host word this cycle
//   endpoint_req_v_o     - head entry valid toward the endpoint
//   endpoint_req_data_o  - head entry data
//   endpoint_req_ready_i - endpoint accepts the head entry
//   out_credits_i        - endpoint remaining credits
//   fence_i              - pulse: block new requests until all complete
//   flush_i              - pulse: discard all queued entries
//   fence_done_o         - one-cycle pulse when a fence completes
//   idle_o               - queue empty and every credit returned
//   occupancy_o          - entries currently queued
//   sent_count_o         - words handed to the endpoint since reset (wraps)
// -----------------------------------------------------------------------------
module bsg_manycore_dpi_req_buffer #(
   parameter int fifo_width_p            = 128,
   parameter int els_p                   = 4,
   parameter int max_out_credits_p       = 32,
   parameter int credit_counter_width_lp = $clog2(max_out_credits_p + 1),
   parameter int count_width_lp          = $clog2(els_p + 1)
) (
   input  logic                               clk_i,
   input  logic                               reset_i,

   input  logic                               host_req_v_i,
   input  logic [fifo_width_p-1:0]            host_req_data_i,
   output logic                               host_req_ready_o,

   output logic                               endpoint_req_v_o,
   output logic [fifo_width_p-1:0]            endpoint_req_data_o,
   input  logic                               endpoint_req_ready_i,
   input  logic [credit_counter_width_lp-1:0] out_credits_i,

   input  logic                               fence_i,
   input  logic                               flush_i,
   output logic                               fence_done_o,
   output logic                               idle_o,
   output logic [count_width_lp-1:0]          occupancy_o,
   output logic [31:0]                        sent_count_o
);

   localparam int ptr_width_lp = $clog2(els_p);

   localparam logic [count_width_lp-1:0]          lp_els_count   = count_width_lp'(els_p);
   localparam logic [credit_counter_width_lp-1:0] lp_max_credits = credit_counter_width_lp'(max_out_credits_p);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FENCE = 2'd1,
      ST_FLUSH = 2'd2
   } state_e;

   // --------------------------------------------------------------------------
   // State
   // --------------------------------------------------------------------------
   state_e                      r_state;
   logic [ptr_width_lp-1:0]     r_rd_ptr;
   logic [ptr_width_lp-1:0]     r_wr_ptr;
   logic [count_width_lp-1:0]   r_occupancy;
   logic [31:0]                 r_sent_count;
   logic                        r_fence_done;

   // --------------------------------------------------------------------------
   // Combinational control
   // --------------------------------------------------------------------------
   logic w_empty;
   logic w_credits_full;
   logic w_push;
   logic w_pop;
   logic w_flush_take;
   logic w_push_eff;
   logic w_pop_eff;

   assign w_empty        = (r_occupancy == '0);
   assign w_credits_full = (out_credits_i == lp_max_credits);

   // Ready depends only on state and occupancy so the host can never create
   // a combinational loop through its valid.
   assign host_req_ready_o = (r_state == ST_RUN) && (r_occupancy < lp_els_count);
   assign endpoint_req_v_o = !w_empty && (out_credits_i != '0) && (r_state != ST_FLUSH);

   assign w_push = host_req_v_i & host_req_ready_o;
   assign w_pop  = endpoint_req_v_o & endpoint_req_ready_i;

   // A flush pulse is ignored while already flushing. When it is taken, any
   // push or pop in that same cycle is thrown away along with the queue.
   assign w_flush_take = flush_i && (r_state != ST_FLUSH);
   assign w_push_eff   = w_push & ~w_flush_take;
   assign w_pop_eff    = w_pop  & ~w_flush_take;

   // --------------------------------------------------------------------------
   // Storage: one register per entry, written when the write pointer selects
   // it. The head is read combinationally from the entry at the read pointer;
   // since writes land on the clock edge there is no same-cycle bypass.
   // --------------------------------------------------------------------------
   logic [fifo_width_p-1:0] w_entry_data [els_p];

   genvar gi;
   generate
      for (gi = 0; gi < els_p; gi++) begin : g_entry
         logic [fifo_width_p-1:0] r_data;

         always_ff @(posedge clk_i) begin
            if (w_push_eff && (r_wr_ptr == ptr_width_lp'(gi))) begin
               r_data <= host_req_data_i;
            end
         end

         assign w_entry_data[gi] = r_data;
      end
   endgenerate

   assign endpoint_req_data_o = w_entry_data[r_rd_ptr];

   // --------------------------------------------------------------------------
   // Pointers, occupancy, sent counter and control FSM
   // --------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state      <= ST_RUN;
         r_rd_ptr     <= '0;
         r_wr_ptr     <= '0;
         r_occupancy  <= '0;
         r_sent_count <= '0;
         r_fence_done <= 1'b0;
      end else begin
         r_fence_done <= 1'b0;

         if (w_flush_take) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_occupancy <= '0;
         end else begin
            // Pointers are log2(els_p) wide, so they wrap on their own.
            if (w_push_eff) begin
               r_wr_ptr <= r_wr_ptr + ptr_width_lp'(1);
            end
            if (w_pop_eff) begin
               r_rd_ptr     <= r_rd_ptr + ptr_width_lp'(1);
               r_sent_count <= r_sent_count + 32'd1;
            end
            case ({w_push_eff, w_pop_eff})
               2'b10:   r_occupancy <= r_occupancy + count_width_lp'(1);
               2'b01:   r_occupancy <= r_occupancy - count_width_lp'(1);
               default: r_occupancy <= r_occupancy;
            endcase
         end

         case (r_state)
            ST_RUN: begin
               if (flush_i) begin
                  r_state <= ST_FLUSH;
               end else if (fence_i) begin
                  r_state <= ST_FENCE;
               end
            end
            ST_FENCE: begin
               // A flush abandons the fence; the host gets no done pulse.
               if (flush_i) begin
                  r_state <= ST_FLUSH;
               end else if (w_empty && w_credits_full) begin
                  r_fence_done <= 1'b1;
                  r_state      <= ST_RUN;
               end
            end
            ST_FLUSH: begin
               // Words already sent must come back before new work starts.
               if (w_credits_full) begin
                  r_state <= ST_RUN;
               end
            end
            default: begin
               r_state <= ST_RUN;
            end
         endcase
      end
   end

   assign fence_done_o = r_fence_done;
   assign idle_o       = w_empty && w_credits_full;
   assign occupancy_o  = r_occupancy;
   assign sent_count_o = r_sent_count;

endmodule

// File: tb/tb_bsg_manycore_dpi_req_buffer.sv
// -----------------------------------------------------------------------------
// Testbench for bsg_manycore_dpi_req_buffer.
// A table of directed vectors covers in-order streaming, full-queue
// backpressure, credit stalls and simultaneous push/pop with pointer wrap.
// Hand-written sequences cover fence, flush, flush during fence and reset
// in the middle of operation.
// -----------------------------------------------------------------------------
module tb_bsg_manycore_dpi_req_buffer;

   localparam int W  = 128;
   localparam int CW = 6;
   localparam int OW = 3;

   logic          clk_i;
   logic          reset_i;
   logic          host_req_v_i;
   logic [W-1:0]  host_req_data_i;
   logic          host_req_ready_o;
   logic          endpoint_req_v_o;
   logic [W-1:0]  endpoint_req_data_o;
   logic          endpoint_req_ready_i;
   logic [CW-1:0] out_credits_i;
   logic          fence_i;
   logic          flush_i;
   logic          fence_done_o;
   logic          idle_o;
   logic [OW-1:0] occupancy_o;
   logic [31:0]   sent_count_o;

   bsg_manycore_dpi_req_buffer dut (
      .clk_i               (clk_i),
      .reset_i             (reset_i),
      .host_req_v_i        (host_req_v_i),
      .host_req_data_i     (host_req_data_i),
      .host_req_ready_o    (host_req_ready_o),
      .endpoint_req_v_o    (endpoint_req_v_o),
      .endpoint_req_data_o (endpoint_req_data_o),
      .endpoint_req_ready_i(endpoint_req_ready_i),
      .out_credits_i       (out_credits_i),
      .fence_i             (fence_i),
      .flush_i             (flush_i),
      .fence_done_o        (fence_done_o),
      .idle_o              (idle_o),
      .occupancy_o         (occupancy_o),
      .sent_count_o        (sent_count_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   typedef struct {
      logic         hv;
      logic [W-1:0] hd;
      logic         rdy;
      int           cr;
      logic         e_rdy;
      logic         e_v;
      logic [W-1:0] e_data;
      int           e_occ;
      int           e_sent;
      logic         e_idle;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   done_pulses = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add(input logic hv, input logic [W-1:0] hd, input logic rdy, input int cr,
                      input logic e_rdy, input logic e_v, input logic [W-1:0] e_data,
                      input int e_occ, input int e_sent, input logic e_idle);
      vec_t v;
      v.hv = hv; v.hd = hd; v.rdy = rdy; v.cr = cr;
      v.e_rdy = e_rdy; v.e_v = e_v; v.e_data = e_data;
      v.e_occ = e_occ; v.e_sent = e_sent; v.e_idle = e_idle;
      vecs.push_back(v);
   endtask

   task automatic set_in(input logic hv, input logic [W-1:0] hd, input logic rdy,
                         input int cr, input logic fen, input logic fl);
      host_req_v_i         = hv;
      host_req_data_i      = hd;
      endpoint_req_ready_i = rdy;
      out_credits_i        = CW'(cr);
      fence_i              = fen;
      flush_i              = fl;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
      if (fence_done_o === 1'b1) done_pulses++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      // ---------------- table contents ----------------
      // hv, hd, rdy, cr | ready, v, data, occ, sent, idle
      // In-order streaming, one cycle latency
      add(1, 'hA, 1, 32, 1, 0, 0,   0, 0, 1);
      add(1, 'hB, 1, 32, 1, 1, 'hA, 1, 0, 0);
      add(1, 'hC, 1, 32, 1, 1, 'hB, 1, 1, 0);
      add(1, 'hD, 1, 32, 1, 1, 'hC, 1, 2, 0);
      add(0, 0,   1, 32, 1, 1, 'hD, 1, 3, 0);
      add(0, 0,   1, 32, 1, 0, 0,   0, 4, 1);
      // Full queue with endpoint stalled
      add(1, 'h10, 0, 32, 1, 0, 0,    0, 4, 1);
      add(1, 'h11, 0, 32, 1, 1, 'h10, 1, 4, 0);
      add(1, 'h12, 0, 32, 1, 1, 'h10, 2, 4, 0);
      add(1, 'h13, 0, 32, 1, 1, 'h10, 3, 4, 0);
      add(1, 'h14, 0, 32, 0, 1, 'h10, 4, 4, 0);
      add(1, 'h14, 1, 32, 0, 1, 'h10, 4, 4, 0);
      add(1, 'h14, 0, 32, 1, 1, 'h11, 3, 5, 0);
      add(0, 0,    1, 32, 0, 1, 'h11, 4, 5, 0);
      add(0, 0,    1, 32, 1, 1, 'h12, 3, 6, 0);
      add(0, 0,    1, 32, 1, 1, 'h13, 2, 7, 0);
      add(0, 0,    1, 32, 1, 1, 'h14, 1, 8, 0);
      add(0, 0,    1, 32, 1, 0, 0,    0, 9, 1);
      // Credit stall
      add(1, 'h20, 1, 0,  1, 0, 0,    0, 9,  0);
      add(1, 'h21, 1, 0,  1, 0, 0,    1, 9,  0);
      add(0, 0,    1, 0,  1, 0, 0,    2, 9,  0);
      add(0, 0,    0, 1,  1, 1, 'h20, 2, 9,  0);
      add(0, 0,    0, 1,  1, 1, 'h20, 2, 9,  0);
      add(0, 0,    1, 1,  1, 1, 'h20, 2, 9,  0);
      add(0, 0,    1, 0,  1, 0, 0,    1, 10, 0);
      add(0, 0,    1, 32, 1, 1, 'h21, 1, 10, 0);
      add(0, 0,    1, 32, 1, 0, 0,    0, 11, 1);
      // Simultaneous push and pop at occupancy 2, pointers wrap
      add(1, 'h30, 0, 32, 1, 0, 0,    0, 11, 1);
      add(1, 'h31, 0, 32, 1, 1, 'h30, 1, 11, 0);
      for (int i = 0; i < 10; i++)
         add(1, W'('h32 + i), 1, 32, 1, 1, W'('h30 + i), 2, 11 + i, 0);
      add(0, 0, 1, 32, 1, 1, 'h3A, 2, 21, 0);
      add(0, 0, 1, 32, 1, 1, 'h3B, 1, 22, 0);
      add(0, 0, 1, 32, 1, 0, 0,    0, 23, 1);

      // ---------------- reset ----------------
      set_in(0, 0, 0, 32, 0, 0);
      reset_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      chk("reset ready", host_req_ready_o, 1);
      chk("reset v_o",   endpoint_req_v_o, 0);
      chk("reset occ",   occupancy_o,      0);
      chk("reset sent",  sent_count_o,     0);
      chk("reset done",  fence_done_o,     0);
      chk("reset idle",  idle_o,           1);
      $display("reset applied and released");
      reset_i = 1'b0;

      // ---------------- table ----------------
      foreach (vecs[k]) begin
         set_in(vecs[k].hv, vecs[k].hd, vecs[k].rdy, vecs[k].cr, 0, 0);
         #1;
         chk($sformatf("vec%0d ready", k), host_req_ready_o, vecs[k].e_rdy);
         chk($sformatf("vec%0d v_o", k),   endpoint_req_v_o, vecs[k].e_v);
         if (vecs[k].e_v)
            chk($sformatf("vec%0d data", k), endpoint_req_data_o, vecs[k].e_data);
         chk($sformatf("vec%0d occ", k),  occupancy_o,  W'(vecs[k].e_occ));
         chk($sformatf("vec%0d sent", k), sent_count_o, W'(vecs[k].e_sent));
         chk($sformatf("vec%0d idle", k), idle_o,       vecs[k].e_idle);
         chk($sformatf("vec%0d done", k), fence_done_o, 0);
         $display("vec %0d: hv=%0b hd=%0h rdy=%0b cr=%0d -> v=%0b data=%0h occ=%0d sent=%0d",
                  k, vecs[k].hv, vecs[k].hd, vecs[k].rdy, vecs[k].cr,
                  endpoint_req_v_o, endpoint_req_data_o, occupancy_o, sent_count_o);
         tick();
      end

      // ---------------- fence ----------------
      done_pulses = 0;
      set_in(1, 'h50, 0, 32, 0, 0); tick();
      set_in(1, 'h51, 0, 32, 0, 0); tick();
      set_in(1, 'h52, 0, 32, 0, 0); tick();
      set_in(0, 0, 0, 32, 1, 0); #1;
      chk("fence entry ready", host_req_ready_o, 1);
      chk("fence entry occ",   occupancy_o, 3);
      tick();
      set_in(1, 'h99, 0, 32, 0, 0); #1;
      chk("fence ready low", host_req_ready_o, 0);
      tick();
      chk("fence push blocked occ", occupancy_o, 3);
      for (int i = 0; i < 3; i++) begin
         set_in(0, 0, 1, 32, 0, 0); #1;
         chk($sformatf("fence drain%0d data", i), endpoint_req_data_o, W'('h50 + i));
         chk($sformatf("fence drain%0d ready", i), host_req_ready_o, 0);
         tick();
      end
      set_in(0, 0, 1, 30, 0, 0); #1;
      chk("fence wait occ",  occupancy_o, 0);
      chk("fence wait done", fence_done_o, 0);
      chk("fence wait ready", host_req_ready_o, 0);
      tick();
      chk("fence no early done", fence_done_o, 0);
      set_in(0, 0, 1, 32, 0, 0); #1;
      chk("fence credits back ready", host_req_ready_o, 0);
      tick();
      chk("fence done pulse", fence_done_o, 1);
      chk("fence back to run", host_req_ready_o, 1);
      tick();
      chk("fence done cleared", fence_done_o, 0);
      tick();
      chk("fence single pulse", W'(done_pulses), 1);
      chk("fence sent", sent_count_o, 26);
      $display("fence sequence: pulses=%0d sent=%0d", done_pulses, sent_count_o);

      // ---------------- flush with pop in flight ----------------
      done_pulses = 0;
      set_in(1, 'h60, 0, 32, 0, 0); tick();
      set_in(1, 'h61, 0, 32, 0, 0); tick();
      set_in(1, 'h62, 0, 32, 0, 0); tick();
      set_in(0, 0, 1, 32, 0, 1); #1;
      chk("flush pop v_o", endpoint_req_v_o, 1);
      chk("flush pop data", endpoint_req_data_o, 'h60);
      chk("flush pre occ", occupancy_o, 3);
      tick();
      set_in(1, 'h77, 1, 20, 0, 0); #1;
      chk("flush occ cleared", occupancy_o, 0);
      chk("flush sent held", sent_count_o, 26);
      chk("flush v_o low", endpoint_req_v_o, 0);
      chk("flush ready low", host_req_ready_o, 0);
      tick();
      set_in(0, 0, 1, 32, 0, 0); #1;
      chk("flush wait ready", host_req_ready_o, 0);
      chk("flush push ignored", occupancy_o, 0);
      tick();
      set_in(1, 'h80, 0, 32, 0, 0); #1;
      chk("flush back ready", host_req_ready_o, 1);
      chk("flush idle", idle_o, 1);
      tick();
      set_in(0, 0, 1, 32, 0, 0); #1;
      chk("post flush head", endpoint_req_data_o, 'h80);
      chk("post flush occ", occupancy_o, 1);
      tick();
      chk("post flush sent", sent_count_o, 27);
      chk("flush no done", W'(done_pulses), 0);
      $display("flush sequence: occ=%0d sent=%0d", occupancy_o, sent_count_o);

      // ---------------- flush during fence ----------------
      done_pulses = 0;
      set_in(1, 'h90, 0, 32, 0, 0); tick();
      set_in(0, 0, 0, 32, 1, 0); tick();
      set_in(0, 0, 0, 32, 0, 1); #1;
      chk("fence-flush ready", host_req_ready_o, 0);
      chk("fence-flush occ", occupancy_o, 1);
      tick();
      set_in(0, 0, 0, 32, 0, 0); #1;
      chk("fence-flush cleared", occupancy_o, 0);
      chk("fence-flush still blocked", host_req_ready_o, 0);
      tick();
      chk("fence-flush run", host_req_ready_o, 1);
      tick();
      chk("fence-flush no done", W'(done_pulses), 0);
      chk("fence-flush sent", sent_count_o, 27);
      $display("flush during fence: pulses=%0d", done_pulses);

      // ---------------- reset mid operation ----------------
      set_in(1, 'h70, 0, 32, 0, 0); tick();
      set_in(1, 'h71, 0, 32, 0, 0); tick();
      chk("pre-reset occ", occupancy_o, 2);
      set_in(0, 0, 0, 32, 0, 0);
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      chk("midreset occ", occupancy_o, 0);
      chk("midreset sent", sent_count_o, 0);
      chk("midreset v_o", endpoint_req_v_o, 0);
      chk("midreset ready", host_req_ready_o, 1);
      $display("reset mid-operation: occ=%0d sent=%0d", occupancy_o, sent_count_o);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/bsg_manycore_dpi_req_buffer.md
Name: bsg_manycore_dpi_req_buffer

Overview:
Request staging buffer between the DPI host tile model and the endpoint FIFO adapter's request port (endpoint_req_*). The DPI side produces 128-bit request words at negedge without regard to backpressure. This block queues them, releases them only when the endpoint reports remote credits, and provides fence/flush control so the host model can wait for all outstanding requests to complete.

Parameters:
fifo_width_p, 128, width of one request word (matches endpoint FIFO word)
els_p, 4, queue depth in entries (power of two, >=2)
max_out_credits_p, 32, endpoint credit pool size
credit_counter_width_lp, $clog2(max_out_credits_p+1), width of credit count
count_width_lp, $clog2(els_p+1), width of occupancy

Ports:
clk_i  input  1  clock
reset_i  input  1  synchronous active-high reset
host_req_v_i  input  1  host request valid
host_req_data_i  input  fifo_width_p  host request word
host_req_ready_o  output  1  buffer accepts host word this cycle
endpoint_req_v_o  output  1  head entry valid toward endpoint
endpoint_req_data_o  output  fifo_width_p  head entry data
endpoint_req_ready_i  input  1  endpoint accepts head
out_credits_i  input  credit_counter_width_lp  endpoint remaining credits (registered; reflects a send by next cycle)
fence_i  input  1  pulse: block new requests until all complete
flush_i  input  1  pulse: discard all queued entries
fence_done_o  output  1  one-cycle pulse when fence completes
idle_o  output  1  queue empty and out_credits_i == max_out_credits_p
occupancy_o  output  count_width_lp  entries currently queued
sent_count_o  output  32  total words handed to endpoint since reset (wraps)

Behaviour:
- Reset: state RUN; rd/wr pointers, occupancy, sent_count = 0. Outputs: endpoint_req_v_o=0, fence_done_o=0, host_req_ready_o=1, occupancy_o=0. idle_o follows its definition.
- Storage: circular buffer of els_p entries. Pointers are log2(els_p) bits and wrap naturally. Occupancy is a separate counter.
- Push: host_req_v_i & host_req_ready_o. Writes at wr_ptr.
- host_req_ready_o = (state==RUN) & (occupancy < els_p). Combinational from state and occupancy only, never from valid.
- Output: endpoint_req_v_o = (occupancy != 0) & (out_credits_i != 0) & (state != FLUSH). Data is the entry at rd_ptr.
- Pop: endpoint_req_v_o & endpoint_req_ready_i. Advances rd_ptr and increments sent_count.
- No bypass: a word pushed into an empty queue becomes visible on endpoint_req_v_o the next cycle (min latency 1).
- Push and pop in the same cycle: occupancy is unchanged and both pointers advance. This is legal at any occupancy below full. At full, push is blocked by ready.
- Credits: if out_credits_i == 0, the head is held and v_o stays low. Data is held stable while valid is asserted.
- FSM states: RUN, FENCE, FLUSH.
  - RUN: fence_i -> FENCE. flush_i -> FLUSH. flush_i has priority if both are asserted.
  - FENCE: host_req_ready_o=0 and the queue keeps draining. When occupancy==0 and out_credits_i==max_out_credits_p: pulse fence_done_o for 1 cycle, then -> RUN. flush_i in FENCE -> FLUSH, and no fence_done is issued.
  - FLUSH: entered with pointers and occupancy cleared on the cycle flush_i is sampled. A pop or push in that same cycle is discarded and sent_count is not incremented. In FLUSH, ready=0 and v_o=0. Wait until out_credits_i==max_out_credits_p, then -> RUN with no done pulse.
  - fence_i/flush_i while already in the target state are ignored.
- idle_o is combinational: (occupancy==0) & (out_credits_i==max_out_credits_p).
- sent_count_o is 32-bit and wraps 0xFFFF_FFFF -> 0.
- reset_i mid-operation returns to the reset state on the next edge. Queued entries are lost.

Test Plan:
- Push 0xA..0xD back-to-back with ready_i=1, credits=32 -> each appears on endpoint_req_data_o one cycle after its push, in order; sent_count_o=4; occupancy returns to 0.
- Hold ready_i=0, push 5 words with els_p=4 -> host_req_ready_o drops after the 4th; occupancy_o=4; the 5th is not accepted until the first pop.
- Queue 2 words, out_credits_i=0 -> endpoint_req_v_o stays 0. Raise credits to 1 -> first word issues; head data is stable while stalled.
- At occupancy 2, simultaneous push+pop for 10 cycles -> occupancy stays 2; pointers wrap past els_p-1 with correct ordering.
- Queue 3 words, pulse fence_i, credits return to 32 after the last send -> host_req_ready_o=0 during the fence; fence_done_o pulses exactly once after occupancy=0 and credits=32.
- Queue 3 words, pulse flush_i while a pop is in flight -> occupancy 0 next cycle; sent_count unchanged for that cycle; v_o=0 until credits=32, then back to RUN with ready=1.
